calib_sweep_fsm: RTL

- Sequences the tracker's calibration sweep: enables the horizontal sweep counter, then the vertical sweep counter, with a settle gap after each.
- During each sweep, records the servo position giving the highest light reading.
- Publishes the best horizontal/vertical positions and a one-cycle DONE pulse; flags ERR if a sweep never completes.
- Sits between the top-level mode FSM (START/ABORT) and the horizontal/vertical sweep counters plus LDR comparator path.

---
 rtl/calib_sweep_fsm.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/calib_sweep_fsm.sv
// calib_sweep_fsm
//   Runs the tracker's calibration sweep: horizontal sweep, settle gap,
//   vertical sweep, settle gap, then publishes the servo positions that
//   produced the highest light reading.
//
// Ports
//   CLK, RST       clock, synchronous active-high reset
//   START, ABORT   level requests from the mode FSM
//   CNT_L, CNT_U   horizontal / vertical sweep counter running
//   LIGHT          current light level (unsigned)
//   POS_H, POS_V   current servo positions
//   HS, VS         horizontal / vertical sweep enables
//   BUSY           high outside IDLE and FAULT
//   DONE           one-cycle completion pulse
//   ERR            high while in FAULT
//   BEST_H, BEST_V best positions from the last completed run
module calib_sweep_fsm #(
  parameter int unsigned LW      = 10,
  parameter int unsigned PW      = 8,
  parameter int unsigned GAP     = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          ABORT,
  input  logic          CNT_L,
  input  logic          CNT_U,
  input  logic [LW-1:0] LIGHT,
  input  logic [PW-1:0] POS_H,
  input  logic [PW-1:0] POS_V,
  output logic          HS,
  output logic          VS,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [PW-1:0] BEST_H,
  output logic [PW-1:0] BEST_V
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_H_SWEEP,
    S_H_GAP,
    S_V_SWEEP,
    S_V_GAP,
    S_FIN,
    S_FAULT
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [LW-1:0] best_light;
  logic [PW-1:0] best_h;
  logic [PW-1:0] best_v;
  logic          seen;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic          cnt_en;
  logic          sweep_done;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a completing sweep takes precedence over the timeout
  always_comb begin
    next_state = state;
    cnt_en     = 1'b0;
    sweep_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) next_state = S_H_SWEEP;
      end
      S_H_SWEEP: begin
        cnt_en     = CNT_L;
        sweep_done = seen & ~CNT_L;
        if (sweep_done)        next_state = S_H_GAP;
        else if (tcnt == T_LAST) next_state = S_FAULT;
      end
      S_H_GAP: begin
        if (gcnt == G_LAST) next_state = S_V_SWEEP;
      end
      S_V_SWEEP: begin
        cnt_en     = CNT_U;
        sweep_done = seen & ~CNT_U;
        if (sweep_done)        next_state = S_V_GAP;
        else if (tcnt == T_LAST) next_state = S_FAULT;
      end
      S_V_GAP: begin
        if (gcnt == G_LAST) next_state = S_FIN;
      end
      S_FIN:   next_state = S_IDLE;
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_IDLE;
    endcase
    if (ABORT) next_state = S_IDLE;
  end

  // Sweep tracking, timeout and gap counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      best_light <= '0;
      best_h     <= '0;
      best_v     <= '0;
      seen       <= 1'b0;
      tcnt       <= '0;
      gcnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (next_state == S_H_SWEEP) begin
            best_light <= '0;
            best_h     <= '0;
            seen       <= 1'b0;
            tcnt       <= '0;
          end
        end
        S_H_SWEEP, S_V_SWEEP: begin
          tcnt <= tcnt + 1'b1;
          if (cnt_en) begin
            seen <= 1'b1;
            // strict compare: on ties the earliest position is kept
            if (LIGHT > best_light) begin
              best_light <= LIGHT;
              if (state == S_H_SWEEP) best_h <= POS_H;
              else                    best_v <= POS_V;
            end
          end
          if (sweep_done) begin
            tcnt <= '0;
            gcnt <= '0;
          end
        end
        S_H_GAP: begin
          gcnt <= gcnt + 1'b1;
          if (next_state == S_V_SWEEP) begin
            best_light <= '0;
            best_v     <= '0;
            seen       <= 1'b0;
            tcnt       <= '0;
          end
        end
        S_V_GAP: gcnt <= gcnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Registered outputs, decoded from the state being entered
  always_ff @(posedge CLK) begin
    if (RST) begin
      HS     <= 1'b0;
      VS     <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
      BEST_H <= '0;
      BEST_V <= '0;
    end else begin
      HS   <= (next_state == S_H_SWEEP);
      VS   <= (next_state == S_V_SWEEP);
      BUSY <= (next_state != S_IDLE) && (next_state != S_FAULT);
      DONE <= (next_state == S_FIN);
      ERR  <= (next_state == S_FAULT);
      if (next_state == S_FIN) begin
        BEST_H <= best_h;
        BEST_V <= best_v;
      end
    end
  end

endmodule
